multdiv_seq: RTL and testbench

- Multi-cycle sequencer for the MIPS MULT/DIV unit; owns the architectural HI/LO registers.
- ctrl_unit pulses start with an operation code and operands taken from regs A/B.
- ctrl_unit then waits on busy/done before issuing MFHI/MFLO.
- One result bit per cycle: radix-2 shift-add multiply, restoring divide on magnitudes with a final sign fix.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_seq.sv | 173 +++++++++++++++++
 tb/tb_multdiv_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and op encodings for the sequential MIPS MULT/DIV unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

endpackage

// File: rtl/multdiv_seq.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; one result bit per cycle.
// Define MULTDIV_UNSIGNED_EN to honour op[1] (MULTU/DIVU); otherwise all ops are signed.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e               r_state, w_state_d;
  logic [CW-1:0]        r_cnt, w_cnt_d;
  logic [2*WIDTH-1:0]   r_acc, w_acc_d;
  logic [WIDTH-1:0]     r_opnd, w_opnd_d;
  logic                 r_is_div, w_is_div_d;
  logic                 r_neg_res, w_neg_res_d;
  logic                 r_neg_rem, w_neg_rem_d;
  logic                 r_dz_pend, w_dz_pend_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;
  logic                 r_div_zero, w_div_zero_d;
  logic [WIDTH-1:0]     r_hi, w_hi_d;
  logic [WIDTH-1:0]     r_lo, w_lo_d;

  logic                 w_signed;
  logic                 w_unused;
`ifdef MULTDIV_UNSIGNED_EN
  assign w_signed = ~i_op[1];
  assign w_unused = 1'b0;
`else
  assign w_signed = 1'b1;
  assign w_unused = i_op[1];
`endif

  logic                 w_neg_a, w_neg_b, w_b_zero;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  assign w_neg_a  = w_signed & i_a[WIDTH-1];
  assign w_neg_b  = w_signed & i_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? (~i_a + 1'b1) : i_a;
  assign w_mag_b  = w_neg_b ? (~i_b + 1'b1) : i_b;
  assign w_b_zero = (i_b == '0);

  // Multiply step: conditionally add multiplicand into the upper half, then shift right.
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mult_next;
  assign w_msum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mult_next = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring divide step: {rem, quot} shifts left, quotient bit enters at the bottom.
  logic [WIDTH:0]       w_rsh, w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  assign w_rsh      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rsh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot, w_rem;
  assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_acc_d      = r_acc;
    w_opnd_d     = r_opnd;
    w_is_div_d   = r_is_div;
    w_neg_res_d  = r_neg_res;
    w_neg_rem_d  = r_neg_rem;
    w_dz_pend_d  = r_dz_pend;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;
    w_div_zero_d = r_div_zero;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_busy_d     = 1'b1;
          w_div_zero_d = 1'b0;
          w_cnt_d      = '0;
          w_is_div_d   = i_op[0];
          w_neg_res_d  = w_neg_a ^ w_neg_b;
          w_neg_rem_d  = w_neg_a;
          w_dz_pend_d  = i_op[0] & w_b_zero;
          w_opnd_d     = i_op[0] ? w_mag_b : w_mag_a;
          w_acc_d      = i_op[0] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
          if (i_op[0] && w_b_zero) w_state_d = FIX;
          else if (i_op[0])        w_state_d = DIV;
          else                     w_state_d = MULT;
        end
      end
      MULT, DIV: begin
        w_acc_d = (r_state == MULT) ? w_mult_next : w_div_next;
        if (r_cnt == CNT_LAST) begin
          w_cnt_d   = '0;
          w_state_d = FIX;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      FIX: begin
        if (r_dz_pend) begin
          w_div_zero_d = 1'b1;
        end else if (r_is_div) begin
          w_hi_d = w_rem;
          w_lo_d = w_quot;
        end else begin
          w_hi_d = w_prod[2*WIDTH-1:WIDTH];
          w_lo_d = w_prod[WIDTH-1:0];
        end
        w_dz_pend_d = 1'b0;
        w_busy_d    = 1'b0;
        w_done_d    = 1'b1;
        w_state_d   = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_acc      <= w_acc_d;
      r_opnd     <= w_opnd_d;
      r_is_div   <= w_is_div_d;
      r_neg_res  <= w_neg_res_d;
      r_neg_rem  <= w_neg_rem_d;
      r_dz_pend  <= w_dz_pend_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_div_zero <= w_div_zero_d;
      r_hi       <= w_hi_d;
      r_lo       <= w_lo_d;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: stimulus pushes expected results, a monitor checks on done.
module tb_multdiv_seq;

  localparam int W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic          o_busy, o_done, o_div_zero;
  logic [W-1:0]  o_hi, o_lo;

  multdiv_seq #(.WIDTH(W)) u_dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    int           tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_tag  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Drive a start; the accepting edge is the next posedge. Operands are scrambled afterwards.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                       input int lat, input bit push);
    exp_t e;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    i_op    = 2'($urandom);
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dz  = edz;
      e.cyc = cyc + lat;
      e.tag = n_tag++;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge i_clk);
      #2;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(o_done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("hi[%0d]", e.tag), 64'(o_hi), 64'(e.hi));
          chk($sformatf("lo[%0d]", e.tag), 64'(o_lo), 64'(e.lo));
          chk($sformatf("div_zero[%0d]", e.tag), 64'(o_div_zero), 64'(e.dz));
          chk($sformatf("busy_at_done[%0d]", e.tag), 64'(o_busy), 64'd0);
          chk($sformatf("latency[%0d]", e.tag), 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_div_zero", 64'(o_div_zero), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 7 * -3 with busy held throughout
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, W + 1, 1'b1);
    chk("busy_e0", 64'(o_busy), 64'd1);
    for (int i = 0; i < W; i++) begin
      @(negedge i_clk);
      chk($sformatf("busy_c%0d", i + 1), 64'(o_busy), 64'd1);
    end
    drain();

    issue(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, W + 1, 1'b1);
    drain();

    // -7 / 2, then a start in the done cycle: -2^31 / -1
    issue(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1, 1'b1);
    wait_done();
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, W + 1, 1'b1);
    drain();

    // Preload hi=0x11 lo=0x22 via 0x451/0x20, then divide by zero
    issue(2'b01, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, W + 1, 1'b1);
    drain();
    issue(2'b01, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, 1'b1);
    drain();

    // Second start during MULT is ignored; div_zero clears on this accepted start
    issue(2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, W + 1, 1'b1);
    chk("dz_cleared", 64'(o_div_zero), 64'd0);
    repeat (4) @(negedge i_clk);
    i_op    = 2'b01;
    i_a     = 32'd100;
    i_b     = 32'd7;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    drain();

`ifdef MULTDIV_UNSIGNED_EN
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, W + 1, 1'b1);
`else
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, W + 1, 1'b1);
`endif
    drain();

    // Asynchronous reset mid-MULT, away from any clock edge
    issue(2'b00, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, W + 1, 1'b0);
    repeat (9) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_hi", 64'(o_hi), 64'd0);
    chk("arst_lo", 64'(o_lo), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    issue(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1, 1'b1);
    drain();
    repeat (40) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
